// File: rtl/vga_capture_pkg.sv
// Shared types and constants for the VGA single-frame grabber.
package vga_capture_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StCapture,
        StDrain
    } cap_state_e;

    localparam int unsigned DROP_W = 16;

    // FIFO entry is {pixel, sof, eol}.
    function automatic int unsigned entry_w(input int unsigned ch_w);
        return 3 * ch_w + 2;
    endfunction

endpackage

// File: rtl/vga_frame_capture_if.sv
// Valid/ready pixel stream leaving the frame grabber.
interface vga_frame_capture_if #(
    parameter int unsigned CH_W = 8
) ();
    logic [3*CH_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_sof;
    logic              pix_eol;

    modport master (
        output pix_data, pix_valid, pix_sof, pix_eol,
        input  pix_ready
    );

    modport slave (
        input  pix_data, pix_valid, pix_sof, pix_eol,
        output pix_ready
    );
endinterface

// File: rtl/vga_capture_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
module vga_capture_fifo #(
    parameter int unsigned  WIDTH = 8,
    parameter int unsigned  DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    localparam logic [CW-1:0] CntFull = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_wr, do_rd;

    assign full_o  = (cnt_q == CntFull);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign do_rd   = rd_en_i && !empty_o;
    // A write into a full FIFO is accepted only when the head leaves the same cycle.
    assign do_wr   = wr_en_i && (!full_o || do_rd);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_wr) wptr_d = wptr_q + 1'b1;
        if (do_rd) rptr_d = rptr_q + 1'b1;
        if (do_wr && !do_rd) cnt_d = cnt_q + 1'b1;
        else if (!do_wr && do_rd) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/vga_frame_capture.sv
// Grabs one active VGA frame into a valid/ready pixel stream with sof/eol markers.
// Define VGA_CAPTURE_CROP_EN to add a rectangular crop window sampled on start_i.
module vga_frame_capture
    import vga_capture_pkg::*;
#(
    parameter int unsigned  H_ACTIVE   = 640,
    parameter int unsigned  V_ACTIVE   = 480,
    parameter int unsigned  CH_W       = 8,
    parameter int unsigned  FIFO_DEPTH = 16,
    parameter bit           VS_POL     = 1'b0,
    localparam int unsigned ColW       = $clog2(H_ACTIVE),
    localparam int unsigned LineW      = $clog2(V_ACTIVE + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic                        vsync_i,
    input  logic                        blank_n_i,
    input  logic [3*CH_W-1:0]           rgb_i,
`ifdef VGA_CAPTURE_CROP_EN
    input  logic [ColW-1:0]             crop_x0_i,
    input  logic [ColW-1:0]             crop_x1_i,
    input  logic [$clog2(V_ACTIVE)-1:0] crop_y0_i,
    input  logic [$clog2(V_ACTIVE)-1:0] crop_y1_i,
`endif
    vga_frame_capture_if.master         pix,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        overflow_o,
    output logic [DROP_W-1:0]           drop_count_o
);
    localparam int unsigned      EntryW  = entry_w(CH_W);
    localparam int unsigned      CntW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [ColW-1:0]  ColLast = ColW'(H_ACTIVE - 1);
    localparam logic [LineW-1:0] LineEnd = LineW'(V_ACTIVE);

    cap_state_e        state_q, state_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [LineW-1:0]  line_q, line_d, line_nxt;
    logic              line_full_q, line_full_d;
    logic              vs_act_q, blank_q;
    logic              busy_q, busy_d, done_q, done_d, overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              vs_act, vs_fall, blank_fall, pop, active;
    logic              in_win, sof, eol, frame_end;
    logic              push_req, fifo_wr, drop;
    logic              fifo_full, fifo_empty;
    logic [CntW-1:0]   fifo_cnt;
    logic [EntryW-1:0] fifo_rdata;

    assign vs_act     = (vsync_i == VS_POL);
    assign vs_fall    = vs_act_q && !vs_act;
    assign blank_fall = blank_q && !blank_n_i;
    assign pop        = !fifo_empty && pix.pix_ready;
    assign line_nxt   = line_q + 1'b1;
    // line_full_q stops col at the last pixel so overlong lines are discarded silently.
    assign active     = (state_q == StCapture) && blank_n_i && !line_full_q;
    assign push_req   = active && in_win;
    assign fifo_wr    = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;

`ifdef VGA_CAPTURE_CROP_EN
    logic [ColW-1:0]  x0_q, x1_q;
    logic [LineW-1:0] y0_q, y1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_q <= '0;
            x1_q <= '0;
            y0_q <= '0;
            y1_q <= '0;
        end else if (state_q == StIdle && start_i) begin
            x0_q <= crop_x0_i;
            x1_q <= crop_x1_i;
            y0_q <= LineW'(crop_y0_i);
            y1_q <= LineW'(crop_y1_i);
        end
    end

    always_comb begin
        in_win    = (col_q >= x0_q) && (col_q <= x1_q) && (line_q >= y0_q) && (line_q <= y1_q);
        sof       = (line_q == y0_q) && (col_q == x0_q);
        eol       = (col_q == x1_q);
        // An empty Y range runs to the natural end of the frame.
        frame_end = (line_nxt == LineEnd) || ((y0_q <= y1_q) && (line_q == y1_q));
    end
`else
    always_comb begin
        in_win    = 1'b1;
        sof       = (line_q == '0) && (col_q == '0);
        eol       = (col_q == ColLast);
        frame_end = (line_nxt == LineEnd);
    end
`endif

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        line_d      = line_q;
        line_full_d = line_full_q;
        done_d      = 1'b0;
        overflow_d  = overflow_q;
        drop_d      = drop_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StArm;
                    overflow_d = 1'b0;
                    drop_d     = '0;
                end
            end
            StArm: begin
                if (vs_fall) begin
                    state_d     = StCapture;
                    col_d       = '0;
                    line_d      = '0;
                    line_full_d = 1'b0;
                end
            end
            StCapture: begin
                if (active) begin
                    if (col_q == ColLast) line_full_d = 1'b1;
                    else                  col_d       = col_q + 1'b1;
                end
                if (drop) begin
                    overflow_d = 1'b1;
                    if (drop_q != '1) drop_d = drop_q + 1'b1;
                end
                if (blank_fall) begin
                    col_d       = '0;
                    line_full_d = 1'b0;
                    line_d      = line_nxt;
                    if (frame_end) state_d = StDrain;
                end
                if (vs_act) state_d = StDrain;
            end
            StDrain: begin
                if (fifo_empty || (fifo_cnt == CntW'(1) && pop)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            col_q       <= '0;
            line_q      <= '0;
            line_full_q <= 1'b0;
            vs_act_q    <= 1'b0;
            blank_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            line_q      <= line_d;
            line_full_q <= line_full_d;
            vs_act_q    <= vs_act;
            blank_q     <= blank_n_i;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            drop_q      <= drop_d;
        end
    end

    vga_capture_fifo #(
        .WIDTH(EntryW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en_i(fifo_wr),
        .wdata_i({rgb_i, sof, eol}),
        .rd_en_i(pop),
        .rdata_o(fifo_rdata),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_cnt)
    );

    assign pix.pix_valid = !fifo_empty;
    assign pix.pix_data  = fifo_rdata[EntryW-1:2];
    assign pix.pix_sof   = fifo_rdata[1];
    assign pix.pix_eol   = fifo_rdata[0];

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Scoreboard bench for vga_frame_capture on an 8x4 frame with a 4-entry FIFO.
`timescale 1ns/1ps
module tb_vga_frame_capture;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int CW = 8;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        vsync = 1'b1;
    logic        blank_n = 1'b0;
    logic [23:0] rgb = '0;
    logic        busy, done, overflow;
    logic [15:0] drop_count;
`ifdef VGA_CAPTURE_CROP_EN
    logic [2:0]  crop_x0 = 3'd0, crop_x1 = 3'd7;
    logic [1:0]  crop_y0 = 2'd0, crop_y1 = 2'd3;
`endif
    int cx0 = 0, cx1 = H - 1, cy0 = 0, cy1 = V - 1;
    bit hold = 1'b0;

    vga_frame_capture_if #(.CH_W(CW)) pix_if ();

    vga_frame_capture #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .CH_W      (CW),
        .FIFO_DEPTH(FD),
        .VS_POL    (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .vsync_i     (vsync),
        .blank_n_i   (blank_n),
        .rgb_i       (rgb),
`ifdef VGA_CAPTURE_CROP_EN
        .crop_x0_i   (crop_x0),
        .crop_x1_i   (crop_x1),
        .crop_y0_i   (crop_y0),
        .crop_y1_i   (crop_y1),
`endif
        .pix         (pix_if),
        .busy_o      (busy),
        .done_o      (done),
        .overflow_o  (overflow),
        .drop_count_o(drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int rx_cnt = 0, sof_cnt = 0, eol_cnt = 0, done_cnt = 0;
    logic [25:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    always @(negedge clk) begin
        if (pix_if.pix_valid && pix_if.pix_ready) begin
            if (exp_q.size() == 0) check_eq("unexpected_pix", 32'(pix_if.pix_data), 32'hDEAD_BEEF);
            else check_eq("pix", {6'd0, pix_if.pix_data, pix_if.pix_sof, pix_if.pix_eol},
                          {6'd0, exp_q.pop_front()});
            rx_cnt++;
            if (pix_if.pix_sof) sof_cnt++;
            if (pix_if.pix_eol) eol_cnt++;
        end
        if (done) begin
            done_cnt++;
            check_eq("done_q_empty", exp_q.size(), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic vsync_pulse();
        vsync = 1'b0;
        repeat (3) tick();
        vsync = 1'b1;
        repeat (2) tick();
    endtask

    task automatic video_line(input int ln, input int len, input bit cap, input bit close,
                              input int tag);
        for (int c = 0; c < len; c++) begin
            blank_n = 1'b1;
            rgb = {8'(tag), 8'(ln), 8'(c)};
            if (cap && ln < V && c < H && c >= cx0 && c <= cx1 && ln >= cy0 && ln <= cy1 &&
                !(hold && ln == 0 && c >= FD))
                exp_q.push_back({rgb, 1'(ln == cy0 && c == cx0), 1'(c == cx1)});
            tick();
        end
        if (close) begin
            blank_n = 1'b0;
            rgb = '0;
            pix_if.pix_ready = 1'b1;
            repeat (3) tick();
        end
    endtask

    task automatic frame(input int l0, input int l1, input int l2, input int l3,
                         input bit cap, input int tag);
        int lens[4] = '{l0, l1, l2, l3};
        vsync_pulse();
        for (int l = 0; l < V; l++) video_line(l, lens[l], cap, 1'b1, tag);
        repeat (4) tick();
    endtask

    task automatic wait_done(input int ref_cnt, input string tag);
        int n = 0;
        while (done_cnt == ref_cnt && n < 200) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check_eq(tag, done_cnt - ref_cnt, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0, r0, s0, e0;
        pix_if.pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_flags", {pix_if.pix_valid, pix_if.pix_sof, pix_if.pix_eol, busy, done,
                               overflow}, 0);
        check_eq("rst_data", 32'(pix_if.pix_data), 0);
        check_eq("rst_drop", 32'(drop_count), 0);
        rst = 1'b0;
        tick();

        // Full frame, raster order.
        d0 = done_cnt; r0 = rx_cnt; s0 = sof_cnt; e0 = eol_cnt;
        pulse_start();
        @(negedge clk);
        check_eq("t1_busy", busy, 1);
        frame(8, 8, 8, 8, 1'b1, 1);
        wait_done(d0, "t1_done");
        check_eq("t1_rx", rx_cnt - r0, 32);
        check_eq("t1_sof", sof_cnt - s0, 1);
        check_eq("t1_eol", eol_cnt - e0, 4);
        check_eq("t1_ovf", overflow, 0);
        check_eq("t1_idle", busy, 0);

        // Backpressure through line 0 overflows the FIFO.
        d0 = done_cnt; r0 = rx_cnt;
        hold = 1'b1;
        pix_if.pix_ready = 1'b0;
        pulse_start();
        frame(8, 8, 8, 8, 1'b1, 2);
        hold = 1'b0;
        wait_done(d0, "t2_done");
        check_eq("t2_rx", rx_cnt - r0, 28);
        check_eq("t2_ovf", overflow, 1);
        check_eq("t2_drop", 32'(drop_count), 4);

        // Start while busy is ignored.
        d0 = done_cnt; r0 = rx_cnt;
        pulse_start();
        repeat (2) tick();
        pulse_start();
        @(negedge clk);
        check_eq("t3_ovf_kept_clear", overflow, 0);
        fork
            frame(8, 8, 8, 8, 1'b1, 3);
            begin
                repeat (20) tick();
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        join
        wait_done(d0, "t3_done");
        check_eq("t3_rx", rx_cnt - r0, 32);
        frame(8, 8, 8, 8, 1'b0, 4);
        check_eq("t3_single_done", done_cnt - d0, 1);
        check_eq("t3_idle", busy, 0);

        // Reset in the middle of line 2.
        d0 = done_cnt;
        pulse_start();
        vsync_pulse();
        video_line(0, 8, 1'b1, 1'b1, 5);
        video_line(1, 8, 1'b1, 1'b1, 5);
        video_line(2, 4, 1'b1, 1'b0, 5);
        rst = 1'b1;
        blank_n = 1'b0;
        @(negedge clk);
        check_eq("t4_rst_flags", {pix_if.pix_valid, pix_if.pix_sof, pix_if.pix_eol, busy, done,
                                  overflow}, 0);
        check_eq("t4_rst_data", 32'(pix_if.pix_data), 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check_eq("t4_no_done", done_cnt - d0, 0);
        r0 = rx_cnt;
        pulse_start();
        frame(8, 8, 8, 8, 1'b1, 6);
        wait_done(d0, "t4_done");
        check_eq("t4_rx", rx_cnt - r0, 32);

        // Overlong then short line.
        d0 = done_cnt; r0 = rx_cnt; e0 = eol_cnt;
        pulse_start();
        frame(10, 6, 8, 8, 1'b1, 7);
        wait_done(d0, "t5_done");
        check_eq("t5_rx", rx_cnt - r0, 30);
        check_eq("t5_eol", eol_cnt - e0, 3);
        check_eq("t5_drop", 32'(drop_count), 0);

`ifdef VGA_CAPTURE_CROP_EN
        // Crop window X 2..5, Y 1..2.
        d0 = done_cnt; r0 = rx_cnt; s0 = sof_cnt; e0 = eol_cnt;
        crop_x0 = 3'd2; crop_x1 = 3'd5; crop_y0 = 2'd1; crop_y1 = 2'd2;
        cx0 = 2; cx1 = 5; cy0 = 1; cy1 = 2;
        pulse_start();
        frame(8, 8, 8, 8, 1'b1, 8);
        wait_done(d0, "t6_done");
        check_eq("t6_rx", rx_cnt - r0, 8);
        check_eq("t6_sof", sof_cnt - s0, 1);
        check_eq("t6_eol", eol_cnt - e0, 2);
        cx0 = 0; cx1 = H - 1; cy0 = 0; cy1 = V - 1;
`endif

        check_eq("final_q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_frame_capture.md
Name: vga_frame_capture

Overview:
- Synthesizable single-frame grabber on the pixel side of Interface_VGA; snoops the RGB, blank and v_sync stream and delivers one complete active frame as a valid/ready pixel stream.
- Pixels leave in raster order with start-of-frame and end-of-line markers, for a downstream BMP/UART dumper.
- Generalises the simulation-only frame dump: parametrised resolution, channel width and buffer depth, with on-chip buffering, overflow accounting and optional crop.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- CH_W, 8, bits per colour channel (pixel = 3*CH_W, ordered {B,G,R})
- FIFO_DEPTH, 16, output FIFO entries (power of two, >=4)
- VS_POL, 0, active level of v_sync (0 = active-low)

Ports:
- Clock  in  1  pixel clock (25 MHz domain)
- Reset  in  1  asynchronous, active-high
- Start  in  1  one-cycle pulse, arms a capture
- VSync  in  1  v_sync from the VGA interface
- BlankN  in  1  1 = active video pixel this cycle
- RGBIn  in  3*CH_W  {B,G,R} pixel sampled with BlankN
- PixData  out  3*CH_W  output pixel
- PixValid  out  1  PixData valid
- PixReady  in  1  sink accepts when PixValid && PixReady
- PixSof  out  1  marks pixel (0,0) of the frame
- PixEol  out  1  marks last pixel of each line
- Busy  out  1  capture in progress (ARM..DRAIN)
- Done  out  1  one-cycle pulse when the last pixel is accepted
- Overflow  out  1  sticky, a pixel was dropped
- DropCount  out  16  dropped pixels, saturates at 16'hFFFF

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, counters 0. Reset mid-capture aborts; no Done.
- FSM states:
  - IDLE: Start -> ARM; clear Overflow and DropCount.
  - ARM: wait for a VSync deassert edge (end of sync pulse), then -> CAPTURE.
  - CAPTURE: each cycle with BlankN=1 and col < H_ACTIVE, write {RGBIn, sof, eol} to the FIFO; col++.
    - BlankN falling edge: col := 0, line++.
    - line == V_ACTIVE -> DRAIN.
  - DRAIN: FIFO empty -> Done pulse, -> IDLE.
- Start outside IDLE is ignored. Busy = state ∈ {ARM, CAPTURE, DRAIN}.
- Sideband: sof = (line==0 && col==0); eol = (col==H_ACTIVE-1).
- Line width: active cycles beyond H_ACTIVE in a line are discarded and not counted as drops. A short line still advances line on the BlankN fall; its eol is never set.
- VSync assert during CAPTURE (frame truncated) -> DRAIN early.
- FIFO: registered output, first-word fall-through.
  - PixValid = !empty; a pop occurs when PixValid && PixReady.
  - Write-to-PixValid latency is 1 cycle.
  - Simultaneous push and pop when full is allowed; count unchanged.
- Write when full and no pop: pixel dropped, Overflow := 1, DropCount++ (saturating). Line/col counters still advance.
- Counter widths: $clog2(H_ACTIVE), $clog2(V_ACTIVE+1).

Optional Feature:
- Macro VGA_CAPTURE_CROP_EN.
- Defined: adds inputs CropX0, CropX1 (width $clog2(H_ACTIVE)) and CropY0, CropY1 (width $clog2(V_ACTIVE)), sampled on Start.
  - Only pixels with CropX0<=col<=CropX1 and CropY0<=line<=CropY1 are written.
  - sof is set at (CropY0, CropX0); eol at col==CropX1.
  - CAPTURE ends after line CropY1.
  - X0>X1 or Y0>Y1: zero pixels; Done after the frame ends.
- Undefined: full frame, ports absent.

Decomposition:
- Package vga_capture_pkg:
  - state enum {IDLE, ARM, CAPTURE, DRAIN}
  - DROP_W=16 constant
  - pixel-plus-sideband struct width helper
- Sub-module vga_capture_fifo: parametrised synchronous FIFO (WIDTH, DEPTH) with full/empty flags; the FSM and counters stay in the top.

Test Plan (H_ACTIVE=8, V_ACTIVE=4, CH_W=8, FIFO_DEPTH=4, PixReady=1 unless stated):
1. Start, then a frame with pixel value = {line,col} pattern -> 32 pixels in order; PixSof only on the first; PixEol on col 7 of each line; one Done; Overflow=0.
2. PixReady held 0 during line 0, then 1 -> 4 pixels buffered, 4 dropped. Overflow=1, DropCount=4; Done still pulses after drain.
3. Start pulsed while Busy; second Start pulsed in CAPTURE -> ignored, exactly one frame delivered.
4. Reset asserted mid-line 2 -> all outputs 0 next edge, no Done, FIFO empty. A new Start then captures a clean 32-pixel frame.
5. Line with 10 active cycles, then one with 6 -> first: 8 pixels, no drops; second: 6 pixels, no eol.
6. VGA_CAPTURE_CROP_EN with X 2..5, Y 1..2 -> 8 pixels. PixSof at (1,2); PixEol at cols 5; Done after line 2.
